alu_mul_seq: RTL and testbench

//  Multi-cycle 32x32->64 multiply sequencer built around the shared 32-bit ALU.

---
 rtl/alu_mul_seq_pkg.sv | 30 +++
 rtl/alu_mul_seq_if.sv | 23 ++
 rtl/alu_mul_seq.sv | 135 +++++++++++++
 tb/tb_alu_mul_seq.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_mul_seq_pkg.sv
// Shared definitions for the multiply sequencer: ALU opcodes, comparator
// sub-codes and the sequencer state encoding.
package alu_mul_seq_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_COMP = 4'b0111;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_NAND = 4'b1101;

  localparam logic [2:0] COMP_EQ  = 3'b000;
  localparam logic [2:0] COMP_NE  = 3'b001;
  localparam logic [2:0] COMP_LT  = 3'b010;
  localparam logic [2:0] COMP_GE  = 3'b011;
  localparam logic [2:0] COMP_LTU = 3'b100;
  localparam logic [2:0] COMP_GEU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_NEG_A  = 3'd1,
    S_NEG_B  = 3'd2,
    S_MUL    = 3'd3,
    S_FIX_LO = 3'd4,
    S_FIX_HI = 3'd5,
    S_DONE   = 3'd6
  } state_t;

endpackage

// File: rtl/alu_mul_seq_if.sv
// Operand/product handshake between the EX stage and the multiply sequencer.
interface alu_mul_seq_if #(
  parameter int WIDTH = 32
);
  logic               in_valid;
  logic               in_ready;
  logic               in_signed;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_prod;

  modport master (
    output in_valid, in_signed, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_prod
  );

  modport slave (
    input  in_valid, in_signed, in_a, in_b, out_ready,
    output in_ready, out_valid, out_prod
  );
endinterface

// File: rtl/alu_mul_seq.sv
// Multi-cycle 32x32->64 multiply that borrows the shared EX-stage ALU: magnitude
// negation, 32 shift-add steps, then a 64-bit two's-complement fixup.
module alu_mul_seq
  import alu_mul_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_mul_seq_if.slave     bus,
  output logic [WIDTH-1:0] alu_src1,
  output logic [WIDTH-1:0] alu_src2,
  output logic [3:0]       alu_ctrl,
  output logic [2:0]       alu_comp,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_cout
);

  state_t             state;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic [WIDTH-1:0]   mcand;
  logic [CNT_W-1:0]   cnt;
  logic               neg;
  logic               sgn;
  logic               lz;

  assign bus.out_prod = {hi, lo};

  // ALU operands are pure decode of state; idle cycles issue a harmless 0+0.
  always_comb begin
    alu_src1 = '0;
    alu_src2 = '0;
    alu_ctrl = ALU_ADD;
    alu_comp = COMP_EQ;
    case (state)
      S_NEG_A: begin
        alu_ctrl = ALU_SUB;
        alu_src2 = mcand;
      end
      S_NEG_B, S_FIX_LO: begin
        alu_ctrl = ALU_SUB;
        alu_src2 = lo;
      end
      S_MUL: begin
        alu_src1 = hi;
        alu_src2 = lo[0] ? mcand : '0;
      end
      S_FIX_HI: begin
        if (neg) begin
          if (lz) begin
            alu_ctrl = ALU_SUB;
            alu_src2 = hi;
          end else begin
            alu_ctrl = ALU_NOR;
            alu_src1 = hi;
            alu_src2 = hi;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      hi            <= '0;
      lo            <= '0;
      mcand         <= '0;
      cnt           <= '0;
      neg           <= 1'b0;
      sgn           <= 1'b0;
      lz            <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            lo           <= bus.in_b;
            mcand        <= bus.in_a;
            hi           <= '0;
            neg          <= bus.in_signed & (bus.in_a[WIDTH-1] ^ bus.in_b[WIDTH-1]);
            sgn          <= bus.in_signed;
            bus.in_ready <= 1'b0;
            state        <= S_NEG_A;
          end
        end
        S_NEG_A: begin
          if (sgn && mcand[WIDTH-1]) mcand <= alu_result;
          state <= S_NEG_B;
        end
        S_NEG_B: begin
          // lo still holds the raw multiplier here, so lo[MSB] is its sign.
          if (sgn && lo[WIDTH-1]) lo <= alu_result;
          cnt   <= '0;
          state <= S_MUL;
        end
        S_MUL: begin
          {hi, lo} <= {alu_cout, alu_result, lo[WIDTH-1:1]};
          cnt      <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) state <= S_FIX_LO;
        end
        S_FIX_LO: begin
          if (neg) begin
            lo <= alu_result;
            lz <= (lo == '0);
          end
          state <= S_FIX_HI;
        end
        S_FIX_HI: begin
          // A zero low word carries into hi, so negate it; otherwise just invert.
          if (neg) hi <= alu_result;
          bus.out_valid <= 1'b1;
          state         <= S_DONE;
        end
        S_DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= S_IDLE;
          end
        end
        default: begin
          bus.out_valid <= 1'b0;
          bus.in_ready  <= 1'b1;
          state         <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed and randomized checks of alu_mul_seq paired with a behavioural
// model of the shared 32-bit ALU.
module tb_alu_mul_seq;
  import alu_mul_seq_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] alu_src1;
  logic [31:0] alu_src2;
  logic [3:0]  alu_ctrl;
  logic [2:0]  alu_comp;
  logic [31:0] alu_result;
  logic        alu_cout;

  int checks   = 0;
  int failures = 0;

  alu_mul_seq_if #(.WIDTH(32)) bus ();

  alu_mul_seq #(.WIDTH(32), .CNT_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .alu_src1   (alu_src1),
    .alu_src2   (alu_src2),
    .alu_ctrl   (alu_ctrl),
    .alu_comp   (alu_comp),
    .alu_result (alu_result),
    .alu_cout   (alu_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural shared ALU.
  always_comb begin
    alu_result = '0;
    alu_cout   = 1'b0;
    case (alu_ctrl)
      ALU_AND:  alu_result = alu_src1 & alu_src2;
      ALU_OR:   alu_result = alu_src1 | alu_src2;
      ALU_ADD:  {alu_cout, alu_result} = {1'b0, alu_src1} + {1'b0, alu_src2};
      ALU_SUB:  {alu_cout, alu_result} = {1'b0, alu_src1} + {1'b0, ~alu_src2} + 33'd1;
      ALU_NOR:  alu_result = ~(alu_src1 | alu_src2);
      ALU_NAND: alu_result = ~(alu_src1 & alu_src2);
      default:  alu_result = '0;
    endcase
  end

  // Launches one operation from IDLE and waits for out_valid (bounded).
  // lat is the number of edges from accept to out_valid, -1 on timeout.
  task automatic do_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                       output logic [63:0] p, output int lat);
    bus.in_signed = s;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_valid  = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.out_valid) begin
        lat = i;
        break;
      end
    end
    p = bus.out_prod;
  endtask

  task automatic release_out();
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready);
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid);
    end
    checks++;
    if (bus.out_prod !== 64'h0) begin
      failures++; $display("FAIL reset_out_prod got=%h exp=0", bus.out_prod);
    end
    checks++;
    if ({alu_ctrl, alu_comp, alu_src1, alu_src2} !== {ALU_ADD, 3'b000, 64'h0}) begin
      failures++; $display("FAIL reset_alu_idle got=%h/%h/%h/%h exp=2/0/0/0",
                           alu_ctrl, alu_comp, alu_src1, alu_src2);
    end
  endtask

  task automatic test_unsigned_max();
    logic [63:0] p;
    int lat;
    do_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, p, lat);
    checks++;
    if (lat !== 36) begin
      failures++; $display("FAIL latency got=%0d exp=36", lat);
    end
    checks++;
    if (p !== 64'hFFFFFFFE_00000001) begin
      failures++; $display("FAIL umax_prod got=%h exp=fffffffe00000001", p);
    end
    checks++;
    if (bus.in_ready !== 1'b0) begin
      failures++; $display("FAIL done_in_ready got=%b exp=0", bus.in_ready);
    end
    release_out();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL release got rdy=%b vld=%b exp rdy=1 vld=0",
                           bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_signed();
    logic [63:0] p;
    int lat;
    do_op(1'b1, 32'hFFFFFFFD, 32'h00000005, p, lat);
    checks++;
    if (p !== 64'hFFFFFFFF_FFFFFFF1) begin
      failures++; $display("FAIL sneg3x5 got=%h exp=fffffffffffffff1", p);
    end
    release_out();
    do_op(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, p, lat);
    checks++;
    if (p !== 64'h00000000_00000001) begin
      failures++; $display("FAIL sneg1xneg1 got=%h exp=0000000000000001", p);
    end
    release_out();
  endtask

  task automatic test_boundaries();
    logic [63:0] p;
    int lat;
    do_op(1'b1, 32'h80000000, 32'h80000000, p, lat);
    checks++;
    if (p !== 64'h40000000_00000000) begin
      failures++; $display("FAIL smin_sq got=%h exp=4000000000000000", p);
    end
    release_out();
    do_op(1'b1, 32'h00000000, 32'hFFFFFFF9, p, lat);
    checks++;
    if (p !== 64'h0) begin
      failures++; $display("FAIL szero_lz got=%h exp=0", p);
    end
    release_out();
    do_op(1'b1, 32'h00000002, 32'hFFFFFFFF, p, lat);
    checks++;
    if (p !== 64'hFFFFFFFF_FFFFFFFE) begin
      failures++; $display("FAIL s2xneg1 got=%h exp=fffffffffffffffe", p);
    end
    release_out();
  endtask

  task automatic test_hold();
    logic [63:0] p;
    int lat;
    do_op(1'b0, 32'h12345678, 32'h00000010, p, lat);
    checks++;
    if (p !== 64'h00000001_23456780) begin
      failures++; $display("FAIL hold_prod got=%h exp=0000000123456780", p);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_prod !== 64'h00000001_23456780 ||
          bus.in_ready !== 1'b0) begin
        failures++; $display("FAIL hold_cycle%0d got vld=%b rdy=%b prod=%h exp vld=1 rdy=0 prod=0000000123456780",
                             i, bus.out_valid, bus.in_ready, bus.out_prod);
      end
    end
    release_out();
  endtask

  task automatic test_ignore_in_valid();
    int lat;
    bus.in_signed = 1'b0;
    bus.in_a      = 32'd3;
    bus.in_b      = 32'd4;
    bus.in_valid  = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    bus.in_a     = 32'd100;
    bus.in_b     = 32'd200;
    bus.in_valid = 1'b1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      failures++; $display("FAIL busy_in_ready got=%b exp=0", bus.in_ready);
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat = -1;
    for (int i = 12; i <= 100; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.out_valid) begin
        lat = i;
        break;
      end
    end
    checks++;
    if (lat !== 36 || bus.out_prod !== 64'h0000000C) begin
      failures++; $display("FAIL ignore_pulse got lat=%0d prod=%h exp lat=36 prod=000000000000000c",
                           lat, bus.out_prod);
    end
    release_out();
    repeat (3) @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL no_restart got rdy=%b vld=%b exp rdy=1 vld=0",
                           bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [63:0] p;
    int lat;
    bus.in_signed = 1'b0;
    bus.in_a      = 32'hDEADBEEF;
    bus.in_b      = 32'h0BADF00D;
    bus.in_valid  = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL midop_reset got rdy=%b vld=%b exp rdy=1 vld=0",
                           bus.in_ready, bus.out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op(1'b0, 32'd7, 32'd6, p, lat);
    checks++;
    if (p !== 64'h0000002A || lat !== 36) begin
      failures++; $display("FAIL after_reset got prod=%h lat=%0d exp prod=000000000000002a lat=36", p, lat);
    end
    release_out();
  endtask

  task automatic test_random();
    logic [63:0] p;
    logic [63:0] exp_p;
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic [31:0] a;
    logic [31:0] b;
    logic s;
    int lat;
    for (int n = 0; n < 300; n++) begin
      a = $urandom;
      b = $urandom;
      s = 1'($urandom_range(0, 1));
      if (n % 7 == 0) a = 32'h80000000;
      if (s) begin
        sa    = {{32{a[31]}}, a};
        sb    = {{32{b[31]}}, b};
        exp_p = 64'(sa * sb);
      end else begin
        exp_p = {32'h0, a} * {32'h0, b};
      end
      do_op(s, a, b, p, lat);
      checks++;
      if (p !== exp_p || lat !== 36) begin
        failures++; $display("FAIL rand%0d s=%b a=%h b=%h got=%h lat=%0d exp=%h lat=36",
                             n, s, a, b, p, lat, exp_p);
      end
      release_out();
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_signed = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_unsigned_max();
    test_signed();
    test_boundaries();
    test_hold();
    test_ignore_in_valid();
    test_reset_mid_op();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
